// File: rtl/student_led_fader.sv
// student_led_fader: eight independent LED afterglow channels.
// Each channel jumps to full brightness while its input bit is high. It then
// holds for HoldTicks decay ticks and fades by Step per tick down to zero.
// The prescaler (decay tick) and the 8-bit PWM counter are shared.
// Optional feature macro: STUDENT_LED_FADER_GAMMA_EN enables square-law duty.
// When the macro is undefined, duty equals the level.
module student_led_fader #(
    parameter int DecayDiv  = 50000,
    parameter int Step      = 8,
    parameter int HoldTicks = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  led_i,
    output logic [7:0]  pwm_o,
    output logic [63:0] level_o,
    output logic        active_o
);

    localparam int              PW      = (DecayDiv > 1) ? $clog2(DecayDiv) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(DecayDiv - 1);
    localparam logic [7:0]      STEP_V  = 8'(Step);
    localparam logic [3:0]      HOLD_V  = 4'(HoldTicks);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FADE
    } state_t;

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [7:0]    r_pwm_cnt;
    logic [7:0]    r_pwm;
    logic [7:0]    w_pwm_next;
    logic [7:0]    w_busy_next;
    logic          r_active;

    assign w_tick = (r_presc == PRE_MAX);

    // Decay prescaler: counts 0..DecayDiv-1, tick on the terminal count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Free-running PWM counter, wraps naturally from 255 to 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            state_t     r_state;
            state_t     w_state_next;
            logic [7:0] r_level;
            logic [7:0] w_level_next;
            logic [3:0] r_hold;
            logic [3:0] w_hold_next;
            logic [7:0] w_duty;

            // Channel state, level and hold counter registers.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_state <= ST_IDLE;
                    r_level <= 8'd0;
                    r_hold  <= 4'd0;
                end else begin
                    r_state <= w_state_next;
                    r_level <= w_level_next;
                    r_hold  <= w_hold_next;
                end
            end

            // Next-state logic: a high input bit re-triggers and outranks a tick.
            always_comb begin
                w_state_next = r_state;
                w_level_next = r_level;
                w_hold_next  = r_hold;
                if (led_i[gi]) begin
                    w_state_next = ST_HOLD;
                    w_level_next = 8'hFF;
                    w_hold_next  = HOLD_V;
                end else if (w_tick) begin
                    case (r_state)
                        ST_HOLD: begin
                            if (r_hold != 4'd0) begin
                                w_hold_next = r_hold - 4'd1;
                            end else begin
                                w_state_next = ST_FADE;
                                w_level_next = 8'hFF;
                            end
                        end
                        ST_FADE: begin
                            // Reaching zero also ends the fade on the same edge.
                            if (r_level > STEP_V) begin
                                w_level_next = r_level - STEP_V;
                            end else begin
                                w_level_next = 8'd0;
                                w_state_next = ST_IDLE;
                            end
                        end
                        default: begin
                            w_state_next = ST_IDLE;
                            w_level_next = 8'd0;
                        end
                    endcase
                end
            end

`ifdef STUDENT_LED_FADER_GAMMA_EN
            logic [15:0] w_sq;
            assign w_sq   = {8'd0, r_level} * {8'd0, r_level};
            // Full brightness stays fully on; otherwise use the square law.
            assign w_duty = (r_level == 8'hFF) ? 8'hFF : w_sq[15:8];
`else
            assign w_duty = r_level;
`endif

            assign w_pwm_next[gi]          = (w_duty == 8'hFF) || (r_pwm_cnt < w_duty);
            assign w_busy_next[gi]         = (w_state_next != ST_IDLE);
            assign level_o[8*gi +: 8]      = r_level;
        end
    endgenerate

    // Registered PWM outputs, one cycle behind the level that produced them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pwm <= 8'd0;
        end else begin
            r_pwm <= w_pwm_next;
        end
    end

    // Activity flag follows the channel state registers on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active <= 1'b0;
        end else begin
            r_active <= |w_busy_next;
        end
    end

    assign pwm_o    = r_pwm;
    assign active_o = r_active;

endmodule

// File: tb/tb_student_led_fader.sv
// Directed bench for student_led_fader. The main instance uses DecayDiv=4,
// Step=64 and HoldTicks=2. A second instance uses a long decay period so that
// a level can stay constant across a full PWM period.
module tb_student_led_fader;

    logic        clk;
    logic        rst;
    logic [7:0]  led;
    logic [7:0]  pwm;
    logic [63:0] level;
    logic        active;

    logic        rst_b;
    logic [7:0]  led_b;
    logic [7:0]  pwm_b;
    logic [63:0] level_b;
    logic        active_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int high_cnt = 0;
    int exp_high;

    student_led_fader #(.DecayDiv(4), .Step(64), .HoldTicks(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .led_i    (led),
        .pwm_o    (pwm),
        .level_o  (level),
        .active_o (active)
    );

    student_led_fader #(.DecayDiv(1024), .Step(64), .HoldTicks(0)) dut_b (
        .clk_i    (clk),
        .rst_i    (rst_b),
        .led_i    (led_b),
        .pwm_o    (pwm_b),
        .level_o  (level_b),
        .active_o (active_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        rst   = 1'b1;
        led   = 8'h00;
        rst_b = 1'b1;
        led_b = 8'h00;

        // Reset, with the LED inputs toggled to confirm they are ignored.
        step();
        led = 8'hFF;
        step();
        check("rst_pwm", pwm, 8'h00);
        check("rst_level", level, 64'd0);
        check("rst_active", active, 1'b0);

        // Attack on channel 0 at the first edge after release.
        rst = 1'b0;
        led = 8'h01;
        cyc = 0;
        step();
        check("attack_level", level[7:0], 8'hFF);
        check("attack_active", active, 1'b1);
        check("attack_pwm_lag", pwm, 8'h00);
        led = 8'h00;
        step();
        check("attack_pwm", pwm, 8'h01);

        // Ticks land on edges 4, 8, 12... Hold uses 4 and 8, FADE entry is at 12.
        wait_to(11); check("hold_lvl_e11", level[7:0], 8'hFF);
        wait_to(15); check("fade_entry_e15", level[7:0], 8'hFF);
        wait_to(16); check("fade_191", level[7:0], 8'd191);
        wait_to(19); check("between_ticks", level[7:0], 8'd191);
        wait_to(20); check("fade_127", level[7:0], 8'd127);
        wait_to(24); check("fade_63", level[7:0], 8'd63);
        wait_to(27); check("active_before_idle", active, 1'b1);
        wait_to(28); check("fade_0", level[7:0], 8'd0);
        check("idle_active", active, 1'b0);
        check("other_ch_zero", level[63:8], 56'd0);
        wait_to(29); check("idle_pwm", pwm, 8'h00);

        // Channel 3: fade to 63, then re-trigger on a tick edge.
        led = 8'h08;
        step();
        check("ch3_attack", level[31:24], 8'hFF);
        led = 8'h00;
        wait_to(52); check("ch3_fade_63", level[31:24], 8'd63);
        wait_to(55);
        led = 8'h08;
        step();
        check("prio_level", level[31:24], 8'hFF);
        check("prio_active", active, 1'b1);
        led = 8'h00;
        wait_to(60); check("prio_hold_e60", level[31:24], 8'hFF);
        wait_to(71); check("prio_hold_e71", level[31:24], 8'hFF);
        wait_to(72); check("prio_fade_191", level[31:24], 8'd191);

        // Channel 5: reach 127 in FADE, then reset in the middle of the fade.
        led = 8'h20;
        step();
        check("ch5_attack", level[47:40], 8'hFF);
        led = 8'h00;
        wait_to(92);
        check("ch5_level_vec", level, 64'h0000_7F00_0000_0000);
        check("ch5_pwm_on", pwm[5], 1'b1);
        rst = 1'b1;
        led = 8'hFF;
        step();
        check("midrst_level", level, 64'd0);
        check("midrst_pwm", pwm, 8'h00);
        check("midrst_active", active, 1'b0);
        step();
        check("rst_ignore_led", level, 64'd0);

        // After release nothing may restart without a new trigger.
        rst = 1'b0;
        led = 8'h00;
        cyc = 0;
        wait_to(12);
        check("post_rst_level", level, 64'd0);
        check("post_rst_active", active, 1'b0);
        check("post_rst_pwm", pwm, 8'h00);
        led = 8'h20;
        step();
        led = 8'h00;
        wait_to(27); check("rearm_hold", level[47:40], 8'hFF);
        wait_to(28); check("rearm_fade", level[47:40], 8'd191);

        // Duty measurement: the second instance holds 127 for 1024 cycles.
        rst_b = 1'b0;
        led_b = 8'h01;
        cyc = 0;
        step();
        check("b_attack", level_b[7:0], 8'hFF);
        led_b = 8'h00;
        wait_to(3071); check("b_lvl_191", level_b[7:0], 8'd191);
        wait_to(3072); check("b_lvl_127", level_b[7:0], 8'd127);
        for (int k = 0; k < 256; k++) begin
            step();
            if (pwm_b[0]) high_cnt++;
        end
`ifdef STUDENT_LED_FADER_GAMMA_EN
        exp_high = 63;
`else
        exp_high = 127;
`endif
        check("duty_count", 64'(high_cnt), 64'(exp_high));
        check("b_lvl_still_127", level_b[7:0], 8'd127);
        check("b_active", active_b, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/student_led_fader.md
STUDENT_LED_FADER -- requirements
Module: student_led_fader

Interface
REQ-001 Parameter DecayDiv, default 50000: clock cycles per decay tick (>=1).
REQ-002 Parameter Step, default 8: brightness decrement per tick in FADE (1..255).
REQ-003 Parameter HoldTicks, default 4: ticks at full brightness after led_i bit falls (0..15).
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 led_i  input  8  LED pattern from student_rlight led_o; bit i drives channel i.
REQ-007 pwm_o  output  8  PWM-dimmed LED drive, registered.
REQ-008 level_o  output  64  channel brightness levels; channel i at bits [8i+7:8i].
REQ-009 active_o  output  1  high when any channel is not IDLE, registered.

Function
REQ-010 Prescaler SHALL count 0..DecayDiv-1 and wrap; tick is high for the one cycle in which it equals DecayDiv-1.
REQ-011 The 8-bit PWM counter SHALL increment every cycle and wrap from 255 to 0.
REQ-012 Each channel SHALL own a state machine with states IDLE, HOLD and FADE, an 8-bit level and a 4-bit hold counter.
REQ-013 In any state, led_i[i]=1 SHALL move the channel to HOLD on the next edge, with level=255 and hold counter=HoldTicks.
REQ-014 In HOLD with led_i[i]=0 on a tick, the hold counter SHALL decrement if nonzero; if zero, the channel SHALL enter FADE with level 255.
REQ-015 In FADE with led_i[i]=0 on a tick, level SHALL become level-Step, saturating at 0.
REQ-016 The channel SHALL enter IDLE on the same edge its level becomes 0.
REQ-017 In IDLE with led_i[i]=0, level SHALL hold 0.
REQ-018 Between ticks, level and the hold counter SHALL hold.
REQ-019 If led_i[i]=1 and a tick occur in the same cycle, REQ-013 SHALL take priority.
REQ-020 duty[i] SHALL be derived from level[i] per REQ-031/REQ-032.
REQ-021 pwm_o[i] SHALL be 1 when duty[i]==255; otherwise it SHALL be (pwm_cnt < duty[i]), registered.
REQ-022 A level change at edge N SHALL be reflected in pwm_o at edge N+1.
REQ-023 level_o SHALL expose the level registers directly, with zero added latency.
REQ-024 Channels SHALL be fully independent; the prescaler and PWM counter SHALL be shared.

Reset
REQ-025 While rst_i=1 at a rising edge, the block SHALL clear the prescaler, PWM counter and all hold counters.
REQ-026 While rst_i=1 at a rising edge, all channels SHALL be set to IDLE with level 0.
REQ-027 While rst_i=1 at a rising edge, pwm_o, level_o and active_o SHALL be 0.
REQ-028 Reset asserted mid-HOLD or mid-FADE SHALL abort the fade, with no residual state.
REQ-029 led_i SHALL be ignored while rst_i=1.
REQ-030 After rst_i deasserts, the first tick SHALL occur exactly DecayDiv cycles later.

Configuration
REQ-031 With macro STUDENT_LED_FADER_GAMMA_EN defined, duty SHALL be (level*level)>>8, except level 255 SHALL give duty 255.
REQ-032 Without STUDENT_LED_FADER_GAMMA_EN, duty SHALL equal level.
REQ-033 Only duty is affected by STUDENT_LED_FADER_GAMMA_EN; level_o and state timing SHALL be identical with or without it.

Verification (DecayDiv=4, Step=64, HoldTicks=2)
REQ-034 Reset: rst_i=1 for 2 cycles, then release -> pwm_o=0x00, level_o=0, active_o=0.
REQ-035 Attack: led_i=0x01 for 1 cycle -> level_o[7:0]=255 next edge, pwm_o[0]=1 from following edge, active_o=1.
REQ-036 Hold/fade: after the led_i=0x01 pulse, hold 2 ticks, then level 255 at FADE entry; subsequent ticks give 191, 127, 63, 0, then IDLE and active_o=0.
REQ-037 Duty: channel held at level 127 for 256 cycles -> pwm_o[0] high 127 cycles without macro, 63 cycles with STUDENT_LED_FADER_GAMMA_EN.
REQ-038 Priority: led_i[3]=1 in a tick cycle while channel 3 in FADE at 63 -> level 255, state HOLD, no decrement.
REQ-039 Mid-fade reset: rst_i=1 while channel 5 in FADE at 127 -> level 0, IDLE, pwm_o[5]=0 on that edge.
